// File: rtl/uart_tx_fifo_if.sv
// ============================================================
// Module : uart_tx_fifo_if
// Host-side write port and serial status bundle for uart_tx_fifo.
// Revision: 1.0
// ============================================================
`default_nettype none

interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic                 o_Tx_Ready;
    logic [COUNT_W-1:0]   o_Fifo_Count;
    logic                 o_Overflow;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Active;
    logic                 o_Tx_Done;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Fifo_Count, o_Overflow, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Fifo_Count, o_Overflow, o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================
// Module : uart_tx_fifo
// Buffered UART transmitter: FIFO feeding a back-to-back framer.
// Revision: 1.0
// ============================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);
    localparam logic [15:0]        BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]         STOP_LAST  = 3'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [COUNT_W-1:0]   count;
    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [15:0]          bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 done;
    logic                 overflow;
    logic                 serial;
    logic                 active;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic bit_tick;
    logic last_stop;
    logic parity_bit;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign push       = bus.i_Tx_DV && !fifo_full;
    assign bit_tick   = (bit_cnt == BIT_LAST);
    assign last_stop  = (state == S_STOP) && bit_tick && (bit_idx == STOP_LAST);
    // The head is popped both from idle and on the final stop edge, so queued frames abut.
    assign pop        = !fifo_empty && ((state == S_IDLE) || last_stop);
    assign parity_bit = (^shreg) ^ (PARITY == 2);

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= last_stop;
            overflow <= bus.i_Tx_DV && fifo_full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shreg  <= 8'(mem[rd_ptr]);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if ((state == S_IDLE) || bit_tick) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state_next != state) begin
                bit_idx <= '0;
            end else if (bit_tick && ((state == S_DATA) || (state == S_STOP))) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_next = S_START;
            S_START:  if (bit_tick) state_next = S_DATA;
            S_DATA:   if (bit_tick && (bit_idx == DATA_LAST))
                          state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_tick) state_next = S_STOP;
            S_STOP:   if (last_stop) state_next = fifo_empty ? S_IDLE : S_START;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        serial = 1'b1;
        active = (state != S_IDLE);
        case (state)
            S_START:  serial = 1'b0;
            S_DATA:   serial = shreg[bit_idx];
            S_PARITY: serial = parity_bit;
            default:  serial = 1'b1;
        endcase
    end

    assign bus.o_Tx_Serial  = serial;
    assign bus.o_Tx_Active  = active;
    assign bus.o_Tx_Done    = done;
    assign bus.o_Overflow   = overflow;
    assign bus.o_Fifo_Count = count;
    assign bus.o_Tx_Ready   = !fifo_full;

endmodule

`default_nettype wire
